// File: rtl/sram8_bus_responder.sv
// rtl/sram8_bus_responder.sv - CPU bus responder for an external 8-bit asynchronous SRAM
// Optional one-entry read buffer: define SRAM8_RDBUF_EN.
module sram8_bus_responder #(
  parameter logic [3:0] ADDR_HI     = 4'h6,
  parameter int         SRAM_AW     = 19,
  parameter int         WAIT_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  input  logic [3:0]         data_w_i,
  input  logic [2:0]         data_mode_i,
  output logic [31:0]        data_o,
  output logic               stall_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  input  logic [7:0]         sram_data_i,
  output logic [7:0]         sram_data_o,
  output logic               sram_data_oe_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  logic [1:0]         state;
  logic [SRAM_AW-3:0] word_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [3:0]         be_q;
  logic [3:0]         wait_q;
  logic [1:0]         lane_q;
  logic               after_done_q;

  logic               req;
  logic               hit;
  logic               start;
  logic               is_read;
  logic               last_count;
  logic               last_lane;
  logic [2:0]         first_wr_lane;
  logic [2:0]         next_wr_lane;
  logic [1:0]         first_lane;
  logic [1:0]         next_lane;
  logic [SRAM_AW-3:0] word_in;
  logic               unused_bits;

  // Lowest enabled lane at or above 'from'; 4 means no lane left.
  function automatic logic [2:0] find_lane(input logic [3:0] be, input logic [2:0] from);
    find_lane = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (be[i] && (3'(i) >= from)) find_lane = 3'(i);
    end
  endfunction

  assign unused_bits = ^{data_mode_i, addr_i[27:SRAM_AW], addr_i[1:0], first_wr_lane[2]};

  // Request decode and lane sequencing; the cycle after DONE is masked so a held bus cannot re-trigger.
  always_comb begin
    word_in       = addr_i[SRAM_AW-1:2];
    req           = (addr_i[31:28] == ADDR_HI) && (state == ST_IDLE) && !after_done_q && !rst_i;
    first_wr_lane = find_lane(data_w_i, 3'd0);
    first_lane    = (data_w_i == 4'b0000) ? 2'd0 : first_wr_lane[1:0];
    is_read       = (be_q == 4'b0000);
    next_wr_lane  = find_lane(be_q, {1'b0, lane_q} + 3'd1);
    last_count    = (wait_q == WAIT_LAST);
    last_lane     = is_read ? (lane_q == 2'd3) : next_wr_lane[2];
    next_lane     = is_read ? (lane_q + 2'd1) : next_wr_lane[1:0];
  end

  assign start   = req && !hit;
  assign stall_o = start || (state == ST_ACCESS);

`ifdef SRAM8_RDBUF_EN
  logic               buf_valid;
  logic [SRAM_AW-3:0] buf_tag;
  logic [31:0]        buf_data;

  // A read of the buffered word is answered in the request cycle without touching the SRAM.
  always_comb begin
    hit = req && (data_w_i == 4'b0000) && buf_valid && (buf_tag == word_in);
  end

  assign data_o = hit ? buf_data : rdata_q;

  // Buffer is filled when a read completes and kept coherent by merging completed writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= 32'h0;
    end else if (state == ST_DONE) begin
      if (is_read) begin
        buf_valid <= 1'b1;
        buf_tag   <= word_q;
        buf_data  <= rdata_q;
      end else if (buf_valid && (buf_tag == word_q)) begin
        for (int i = 0; i < 4; i++) begin
          if (be_q[i]) buf_data[8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end
`else
  assign hit    = 1'b0;
  assign data_o = rdata_q;
`endif

  // SRAM pins are driven only while a byte cycle is in progress; async reset clears them at once.
  always_comb begin
    sram_addr_o    = '0;
    sram_data_o    = 8'h00;
    sram_data_oe_o = 1'b0;
    sram_ce_n_o    = 1'b1;
    sram_oe_n_o    = 1'b1;
    sram_we_n_o    = 1'b1;
    if (state == ST_ACCESS) begin
      sram_addr_o = {word_q, lane_q};
      sram_ce_n_o = 1'b0;
      if (is_read) begin
        sram_oe_n_o = 1'b0;
      end else begin
        sram_we_n_o    = 1'b0;
        sram_data_oe_o = 1'b1;
        sram_data_o    = wdata_q[{lane_q, 3'b000} +: 8];
      end
    end
  end

  // Access sequencer: latch request, walk lanes with wait states, report completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      word_q       <= '0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      be_q         <= 4'h0;
      wait_q       <= 4'h0;
      lane_q       <= 2'd0;
      after_done_q <= 1'b0;
    end else begin
      after_done_q <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            word_q  <= word_in;
            wdata_q <= data_i;
            be_q    <= data_w_i;
            lane_q  <= first_lane;
            wait_q  <= 4'h0;
            state   <= ST_ACCESS;
          end else if (hit) begin
            rdata_q <= data_o;
          end
        end
        ST_ACCESS: begin
          if (last_count) begin
            wait_q <= 4'h0;
            if (is_read) rdata_q[{lane_q, 3'b000} +: 8] <= sram_data_i;
            if (last_lane) state <= ST_DONE;
            else lane_q <= next_lane;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram8_bus_responder.sv
// tb/tb_sram8_bus_responder.sv - self-checking bench for sram8_bus_responder
module tb_sram8_bus_responder;

  localparam int WAIT_CYCLES = 1;
  localparam int SRAM_AW     = 19;
  localparam int CYC         = WAIT_CYCLES + 1;

  typedef logic [29:0] ev_t;  // {we_n, oe_n, data_oe, addr[18:0], data_out}

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [3:0]         be;
  logic [2:0]         mode;
  logic [31:0]        data_o;
  logic               stall;
  logic [SRAM_AW-1:0] saddr;
  logic [7:0]         sdi;
  logic [7:0]         sdo;
  logic               soe;
  logic               ce_n;
  logic               oe_n;
  logic               we_n;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  ev_t         trace[$];
  logic [31:0] last_rd;
  bit          bvalid;
  logic [SRAM_AW-3:0] btag;

  always #5 clk = ~clk;

  sram8_bus_responder #(
    .ADDR_HI(4'h6), .SRAM_AW(SRAM_AW), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .data_w_i(be),
    .data_mode_i(mode), .data_o(data_o), .stall_o(stall), .sram_addr_o(saddr),
    .sram_data_i(sdi), .sram_data_o(sdo), .sram_data_oe_o(soe),
    .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n)
  );

  function automatic logic [7:0] init_byte(input int a);
    if (a >= 16 && a < 20) return 8'((a - 15) * 17);
    return 8'((a * 7 + 3) & 255);
  endfunction

  assign sdi = (!ce_n && !oe_n) ? mem[saddr[9:0]] : 8'h00;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (!ce_n) begin
        trace.push_back({we_n, oe_n, soe, saddr, sdo});
        if (!we_n) mem[saddr[9:0]] = sdo;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int stalls, output logic [31:0] rd,
                      output int base);
    @(negedge clk);
    addr = a; wdata = d; be = b; mode = 3'($urandom_range(0, 7));
    base = trace.size();
    #1;
    stalls = 0;
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 200) check({tag, "_timeout"}, 64'(stall), 64'd0);
    rd = data_o;
    @(negedge clk);
    addr = 32'h0; wdata = 32'h0; be = 4'h0;
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b);
    int          exp_stall, got_stall, base, lanes, bi;
    logic [31:0] rd;
    logic [SRAM_AW-3:0] w;
    bit          hit;
    ev_t         exp_tr[$];
    w   = a[SRAM_AW-1:2];
    bi  = int'(a[9:2]) * 4;
    hit = 1'b0;
`ifdef SRAM8_RDBUF_EN
    hit = (b == 4'h0) && bvalid && (btag == w);
`endif
    lanes     = (b == 4'h0) ? 4 : $countones(b);
    exp_stall = hit ? 0 : 1 + lanes * CYC;
    if (!hit) begin
      for (int l = 0; l < 4; l++) begin
        if (b == 4'h0 || b[l]) begin
          repeat (CYC) exp_tr.push_back((b == 4'h0) ? {1'b1, 1'b0, 1'b0, w, 2'(l), 8'h00}
                                                    : {1'b0, 1'b1, 1'b1, w, 2'(l), d[8*l +: 8]});
        end
      end
    end
    if (b == 4'h0) begin
      last_rd = {ref_mem[bi+3], ref_mem[bi+2], ref_mem[bi+1], ref_mem[bi]};
      bvalid  = 1'b1;
      btag    = w;
    end else begin
      for (int l = 0; l < 4; l++) if (b[l]) ref_mem[bi+l] = d[8*l +: 8];
    end
    xact(tag, a, d, b, got_stall, rd, base);
    check({tag, "_stall"}, 64'(got_stall), 64'(exp_stall));
    check({tag, "_data"}, 64'(rd), 64'(last_rd));
    check({tag, "_ncyc"}, 64'(trace.size() - base), 64'(exp_tr.size()));
    for (int i = 0; i < exp_tr.size() && base + i < trace.size(); i++)
      check({tag, "_bus"}, 64'(trace[base+i]), 64'(exp_tr[i]));
  endtask

  initial begin
    int          n, base;
    logic [31:0] a, d;
    logic [3:0]  b;

    rst = 1'b1; addr = 32'h0; wdata = 32'h0; be = 4'h0; mode = 3'b010;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    last_rd = 32'h0;
    bvalid  = 1'b0;
    btag    = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_data", 64'(data_o), 64'd0);
    check("reset_strobes", 64'({ce_n, oe_n, we_n}), 64'(3'b111));
    check("reset_addr", 64'(saddr), 64'd0);
    check("reset_dout", 64'({soe, sdo}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // read of a word preloaded with 0x11..0x44
    run_and_check("rd10", 32'h6000_0010, 32'h0, 4'h0);
    check("rd10_word", 64'(last_rd), 64'h4433_2211);

`ifdef SRAM8_RDBUF_EN
    run_and_check("buf_hit", 32'h6000_0010, 32'h0, 4'h0);
    run_and_check("buf_wr", 32'h6000_0010, 32'h0000_00EE, 4'b0001);
    run_and_check("buf_merge", 32'h6000_0010, 32'h0, 4'h0);
`endif

    // sparse write: lanes 0 and 2 only
    run_and_check("wr20", 32'h6000_0020, 32'hAABB_CCDD, 4'b0101);
    check("wr20_b0", 64'(mem[32'h20]), 64'(8'hDD));
    check("wr20_b1", 64'(mem[32'h21]), 64'(init_byte(32'h21)));
    check("wr20_b2", 64'(mem[32'h22]), 64'(8'hBB));
    check("wr20_b3", 64'(mem[32'h23]), 64'(init_byte(32'h23)));

    // outside the address window: no claim
    @(negedge clk);
    addr = 32'h4000_0000; wdata = 32'h1234_5678; be = 4'hF;
    base = trace.size();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("outside_stall", 64'(stall), 64'd0);
      check("outside_strobes", 64'({ce_n, oe_n, we_n}), 64'(3'b111));
      @(negedge clk);
    end
    check("outside_ncyc", 64'(trace.size() - base), 64'd0);
    addr = 32'h0; be = 4'h0;

    // reset in lane 2 of a full-word write
    @(negedge clk);
    addr = 32'h6000_0080; wdata = 32'h0102_0304; be = 4'hF;
    repeat (1 + 2 * CYC) @(posedge clk);
    #2;
    check("rst_lane2_addr", 64'(saddr), 64'h82);
    check("rst_lane2_we", 64'(we_n), 64'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_strobes", 64'({ce_n, oe_n, we_n}), 64'(3'b111));
    check("rst_mid_stall", 64'(stall), 64'd0);
    check("rst_mid_oe", 64'(soe), 64'd0);
    @(negedge clk);
    addr = 32'h0; be = 4'h0; wdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    bvalid  = 1'b0;
    run_and_check("post_rst_wr", 32'h6000_0084, 32'hCAFE_F00D, 4'hF);
    run_and_check("post_rst_rd", 32'h6000_0084, 32'h0, 4'h0);

    // read held across DONE
    @(negedge clk);
    addr = 32'h6000_0100; be = 4'h0;
    base = trace.size();
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("held_stall", 64'(n), 64'(1 + 4 * CYC));
    check("held_data", 64'(data_o),
          64'({ref_mem[32'h103], ref_mem[32'h102], ref_mem[32'h101], ref_mem[32'h100]}));
    last_rd = {ref_mem[32'h103], ref_mem[32'h102], ref_mem[32'h101], ref_mem[32'h100]};
    @(negedge clk);
    #1;
    check("held_gap_stall", 64'(stall), 64'd0);
    check("held_one_xact", 64'(trace.size() - base), 64'(4 * CYC));
    @(negedge clk);
    #1;
`ifdef SRAM8_RDBUF_EN
    check("held_restall", 64'(stall), 64'd0);
`else
    check("held_restall", 64'(stall), 64'd1);
`endif
    addr = 32'h0;
    bvalid = 1'b1;
    btag   = 17'(32'h100 >> 2);
    @(negedge clk);

    // randomized traffic over a small set of words
    for (int k = 0; k < 24; k++) begin
      a = 32'h6000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      run_and_check("rand", a, d, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
